// File: rtl/tug_scorer.sv
// Tug of War scorer: arbitrates player pushes, tracks the rope position, times the
// random dark wait and drives the LED bar for the master controller.
module tug_scorer #(
  parameter int unsigned NLED      = 9,
  parameter logic [7:0]  LFSR_SEED = 8'hA5,
  parameter int unsigned MIN_WAIT  = 2,
  parameter logic [7:0]  WAIT_MASK = 8'h07
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            slowen_i,
  input  logic            clear_i,
  input  logic            leds_on_i,
  input  logic [1:0]      led_control_i,
  input  logic            pbl_i,
  input  logic            pbr_i,
  output logic [NLED-1:0] leds_o,
  output logic            winrnd_o,
  output logic            rout_o
);

  localparam int unsigned PosW   = $clog2(NLED);
  localparam int unsigned WcntW  = $clog2(MIN_WAIT + 256);
  localparam logic [PosW-1:0]  Center  = PosW'((NLED - 1) / 2);
  localparam logic [PosW-1:0]  LastPos = PosW'(NLED - 1);
  localparam logic [WcntW-1:0] MinWait = WcntW'(MIN_WAIT);

  typedef enum logic [1:0] {
    WinNone,
    WinLeft,
    WinRight
  } win_e;

  // Registered state
  logic [PosW-1:0]  pos_q, pos_d;
  logic             decided_q, decided_d;
  logic             gover_q, gover_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [WcntW-1:0] wcnt_q, wcnt_d;
  logic             blink_q, blink_d;
  logic             dark_q;
  logic [NLED-1:0]  leds_q, leds_d;
  logic             winrnd_q, winrnd_d;
  logic             rout_q, rout_d;

  // Phase decode
  logic dark, play, idle;
  assign dark = ~leds_on_i & ~clear_i;
  assign play =  leds_on_i & ~clear_i;
  assign idle =  clear_i & led_control_i[0];

  // LFSR free-runs every clock
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // Dark wait timer; rout follows a zero count one clock later
  always_comb begin
    wcnt_d = wcnt_q;
    rout_d = 1'b0;
    if (dark && !dark_q) begin
      wcnt_d = MinWait + WcntW'(lfsr_q & WAIT_MASK);
    end else begin
      if (dark && slowen_i && (wcnt_q != '0)) begin
        wcnt_d = wcnt_q - 1'b1;
      end
      rout_d = dark && (wcnt_q == '0);
    end
  end

  // Push arbitration; an early push in the dark hands the round to the opponent
  win_e win;
  always_comb begin
    win = WinNone;
    if (!decided_q && !gover_q && (pbl_i ^ pbr_i)) begin
      if (dark) begin
        win = pbl_i ? WinRight : WinLeft;
      end else if (play) begin
        win = pbl_i ? WinLeft : WinRight;
      end
    end
  end

  // Rope position, round and game-over bookkeeping
  logic [PosW-1:0] pos_step;
  always_comb begin
    pos_step = pos_q;
    unique case (win)
      WinLeft:  pos_step = (pos_q == '0) ? '0 : pos_q - 1'b1;
      WinRight: pos_step = (pos_q == LastPos) ? LastPos : pos_q + 1'b1;
      default:  pos_step = pos_q;
    endcase
  end

  always_comb begin
    pos_d     = pos_q;
    gover_d   = gover_q;
    decided_d = decided_q;
    winrnd_d  = 1'b0;
    if (clear_i) begin
      decided_d = 1'b0;
    end
    if (idle) begin
      pos_d   = Center;
      gover_d = 1'b0;
    end else if (win != WinNone) begin
      pos_d     = pos_step;
      decided_d = 1'b1;
      winrnd_d  = 1'b1;
      if ((pos_step == '0) || (pos_step == LastPos)) begin
        gover_d = 1'b1;
      end
    end
  end

  always_comb begin
    blink_d = blink_q;
    if (gover_q && slowen_i) begin
      blink_d = ~blink_q;
    end
  end

  // LED bar
  logic [NLED-1:0] pos_onehot;
  assign pos_onehot = {{(NLED-1){1'b0}}, 1'b1} << pos_q;

  always_comb begin
    leds_d = '0;
    if (!leds_on_i) begin
      leds_d = '0;
    end else if (led_control_i[0]) begin
      leds_d = '1;
    end else if (gover_q) begin
      leds_d = pos_onehot & {NLED{blink_q}};
    end else begin
      leds_d = pos_onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pos_q     <= Center;
      decided_q <= 1'b0;
      gover_q   <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      wcnt_q    <= '0;
      blink_q   <= 1'b0;
      dark_q    <= 1'b0;
      leds_q    <= '0;
      winrnd_q  <= 1'b0;
      rout_q    <= 1'b0;
    end else begin
      pos_q     <= pos_d;
      decided_q <= decided_d;
      gover_q   <= gover_d;
      lfsr_q    <= lfsr_d;
      wcnt_q    <= wcnt_d;
      blink_q   <= blink_d;
      dark_q    <= dark;
      leds_q    <= leds_d;
      winrnd_q  <= winrnd_d;
      rout_q    <= rout_d;
    end
  end

  assign leds_o   = leds_q;
  assign winrnd_o = winrnd_q;
  assign rout_o   = rout_q;

endmodule

// File: tb/tb_tug_scorer.sv
// Randomized bench for tug_scorer, checked cycle by cycle against a behavioural model.
module tb_tug_scorer;

  localparam int NLED = 9;
  localparam int CENTER = (NLED - 1) / 2;
  localparam int SEED = 8'hA5;
  localparam int MINW = 2;
  localparam int MASK = 8'h07;

  logic            clk = 1'b0;
  logic            rst;
  logic            slowen_i, clear_i, leds_on_i, pbl_i, pbr_i;
  logic [1:0]      led_control_i;
  logic [NLED-1:0] leds_o;
  logic            winrnd_o, rout_o;

  always #5 clk = ~clk;

  tug_scorer dut (
    .clk           (clk),
    .rst           (rst),
    .slowen_i      (slowen_i),
    .clear_i       (clear_i),
    .leds_on_i     (leds_on_i),
    .led_control_i (led_control_i),
    .pbl_i         (pbl_i),
    .pbr_i         (pbr_i),
    .leds_o        (leds_o),
    .winrnd_o      (winrnd_o),
    .rout_o        (rout_o)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_wins = 0;
  int n_gover = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  int m_pos, m_lfsr, m_wait, m_leds;
  bit m_decided, m_gover, m_blink, m_was_dark, m_winrnd, m_rout;

  task automatic model_step(input bit r, s, c, lo, input bit [1:0] lc, input bit bl, br);
    bit dark, play, idle;
    int win, newpos, fb;
    int n_leds;
    bit n_rout, n_blink;
    if (!r) begin
      m_pos = CENTER; m_leds = 0; m_winrnd = 0; m_rout = 0;
      m_decided = 0; m_gover = 0; m_lfsr = SEED; m_wait = 0; m_blink = 0; m_was_dark = 0;
      return;
    end
    dark = !lo && !c;
    play = lo && !c;
    idle = c && lc[0];

    // LED image uses the state before this edge
    if (!lo) n_leds = 0;
    else if (lc[0]) n_leds = (1 << NLED) - 1;
    else if (m_gover) n_leds = m_blink ? (1 << m_pos) : 0;
    else n_leds = 1 << m_pos;

    n_blink = (m_gover && s) ? !m_blink : m_blink;

    if (dark && !m_was_dark) begin
      n_rout = 0;
      m_wait = MINW + (m_lfsr & MASK);
    end else begin
      n_rout = dark && (m_wait == 0);
      if (dark && s && m_wait > 0) m_wait = m_wait - 1;
    end

    win = 0;
    if (!m_decided && !m_gover && (bl != br)) begin
      if (dark) win = bl ? 1 : -1;
      else if (play) win = bl ? -1 : 1;
    end

    m_winrnd = (win != 0);
    if (c) m_decided = 0;
    if (idle) begin
      m_pos = CENTER;
      m_gover = 0;
    end else if (win != 0) begin
      newpos = m_pos + win;
      if (newpos < 0) newpos = 0;
      if (newpos > NLED - 1) newpos = NLED - 1;
      m_pos = newpos;
      m_decided = 1;
      n_wins++;
      if (newpos == 0 || newpos == NLED - 1) begin
        m_gover = 1;
        n_gover++;
      end
    end

    fb = ((m_lfsr >> 7) + (m_lfsr >> 5) + (m_lfsr >> 4) + (m_lfsr >> 3)) % 2;
    m_lfsr = ((m_lfsr * 2) + fb) % 256;
    m_blink = n_blink;
    m_rout = n_rout;
    m_leds = n_leds;
    m_was_dark = dark;
  endtask

  task automatic cycle(input bit r, s, c, lo, input bit [1:0] lc, input bit bl, br);
    rst = r; slowen_i = s; clear_i = c; leds_on_i = lo; led_control_i = lc;
    pbl_i = bl; pbr_i = br;
    @(posedge clk);
    #1;
    model_step(r, s, c, lo, lc, bl, br);
    check_eq("leds", 32'(leds_o), m_leds);
    check_eq("winrnd", 32'(winrnd_o), 32'(m_winrnd));
    check_eq("rout", 32'(rout_o), 32'(m_rout));
  endtask

  task automatic run_phase(input bit c, lo, input bit [1:0] lc, input int len, input int push_pct);
    bit bl, br, s, r;
    int p;
    for (int i = 0; i < len; i++) begin
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 599) != 0);
      bl = 0; br = 0;
      p = $urandom_range(0, 99);
      if (p < push_pct) begin
        p = $urandom_range(0, 9);
        if (p == 0) begin bl = 1; br = 1; end
        else if (p < 5) bl = 1;
        else br = 1;
      end
      cycle(r, s, c, lo, lc, bl, br);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 2'b01, 0, 0);
    // Idle lamp test straight out of reset
    cycle(1, 0, 1, 1, 2'b01, 0, 0);
    check_eq("lamp_test", 32'(leds_o), 32'h1FF);

    for (int rnd = 0; rnd < 300; rnd++) begin
      if (rnd % 7 == 0 || (m_gover && $urandom_range(0, 3) == 0))
        run_phase(1, 1, 2'b01, $urandom_range(2, 5), 20);
      run_phase(0, 0, 2'b00, $urandom_range(2, 30), 3);
      run_phase(0, 1, 2'b10, $urandom_range(2, 10), 35);
      run_phase(1, 1, 2'b10, $urandom_range(2, 8), 20);
      if (rnd % 25 == 24) begin
        for (int k = 0; k < 20; k++)
          cycle($urandom_range(0, 49) != 0, $urandom_range(0, 1) != 0,
                $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                2'($urandom_range(0, 3)), $urandom_range(0, 1) != 0,
                $urandom_range(0, 1) != 0);
      end
    end

    // Mid-play reset
    run_phase(0, 1, 2'b10, 3, 0);
    cycle(0, 0, 0, 1, 2'b10, 0, 0);
    check_eq("rst_leds", 32'(leds_o), 32'h0);
    check_eq("rst_rout", 32'(rout_o), 32'h0);
    cycle(1, 0, 0, 1, 2'b10, 0, 0);
    check_eq("rst_center", 32'(leds_o), 32'(1 << CENTER));

    $display("wins seen %0d, game-overs seen %0d", n_wins, n_gover);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
